// File: rtl/scoreboard_register_file.sv
// ============================================================================
// Module      : scoreboard_register_file
// Description : Register file with per-register pending-write scoreboard,
//               multi-port write-back, WB->read bypass and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scoreboard_register_file #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int WB_PORTS = 2,
    parameter int PEND_W   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic                     rs1_read_i,
    input  logic [$clog2(NREGS)-1:0] rs1_i,
    input  logic                     rs2_read_i,
    input  logic [$clog2(NREGS)-1:0] rs2_i,
    input  logic                     rd_write_i,
    input  logic [$clog2(NREGS)-1:0] rd_i,
    output logic [XLEN-1:0]          rs1_data_o,
    output logic [XLEN-1:0]          rs2_data_o,
    input  logic [WB_PORTS-1:0]      wb_we_i,
    input  logic [WB_PORTS*$clog2(NREGS)-1:0] wb_rd_i,
    input  logic [WB_PORTS*XLEN-1:0] wb_data_i,
    input  logic                     flush_i,
    output logic                     err_o
);

    localparam int AW   = $clog2(NREGS);
    localparam int c_dw = $clog2(WB_PORTS + 1);
    localparam int c_cw = ((PEND_W > c_dw) ? PEND_W : c_dw) + 2;
    localparam logic [PEND_W-1:0] c_pend_max = '1;

    logic [XLEN-1:0]   r_regs [NREGS];
    logic [PEND_W-1:0] r_pend [NREGS];
    logic              r_err;

    logic [c_dw-1:0]   w_dec      [NREGS];
    logic [XLEN-1:0]   w_wb_val   [NREGS];
    logic [NREGS-1:0]  w_hit;
    logic [NREGS-1:0]  w_inc;
    logic [NREGS-1:0]  w_under;
    logic [c_cw-1:0]   w_sum      [NREGS];
    logic [PEND_W-1:0] w_pend_nxt [NREGS];
    logic              w_rs1_ok;
    logic              w_rs2_ok;
    logic              w_rd_ok;
    logic              w_fire;

    // Per-register retire count and winning write-back data (highest port wins)
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            w_dec[r]    = '0;
            w_hit[r]    = 1'b0;
            w_wb_val[r] = '0;
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_we_i[p] && (wb_rd_i[p*AW +: AW] == AW'(r)) && (r != 0)) begin
                    w_dec[r]    = w_dec[r] + c_dw'(1);
                    w_hit[r]    = 1'b1;
                    w_wb_val[r] = wb_data_i[p*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rs1_data_o = '0;
        rs2_data_o = '0;
        if (!rst_i) begin
            if (rs1_i != '0) rs1_data_o = w_hit[rs1_i] ? w_wb_val[rs1_i] : r_regs[rs1_i];
            if (rs2_i != '0) rs2_data_o = w_hit[rs2_i] ? w_wb_val[rs2_i] : r_regs[rs2_i];
        end
    end

    // A source is also ready when every outstanding write retires this cycle
    always_comb begin
        w_rs1_ok = !rs1_read_i || (rs1_i == '0) || (r_pend[rs1_i] == '0) ||
                   (c_cw'(r_pend[rs1_i]) == c_cw'(w_dec[rs1_i]));
        w_rs2_ok = !rs2_read_i || (rs2_i == '0) || (r_pend[rs2_i] == '0) ||
                   (c_cw'(r_pend[rs2_i]) == c_cw'(w_dec[rs2_i]));
        w_rd_ok  = !rd_write_i || (rd_i == '0) || (r_pend[rd_i] != c_pend_max) ||
                   w_hit[rd_i];
    end

    assign issue_ready_o = !rst_i && !flush_i && w_rs1_ok && w_rs2_ok && w_rd_ok;
    assign w_fire        = issue_valid_i && issue_ready_o;
    assign err_o         = r_err;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            w_inc[r]      = w_fire && rd_write_i && (rd_i == AW'(r)) && (r != 0);
            w_sum[r]      = c_cw'(r_pend[r]) + c_cw'(w_inc[r]);
            w_under[r]    = c_cw'(w_dec[r]) > w_sum[r];
            w_pend_nxt[r] = '0;
            if (!w_under[r]) begin
                w_pend_nxt[r] = r_pend[r] + PEND_W'(w_inc[r]) - PEND_W'(w_dec[r]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
                r_pend[r] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (w_hit[r]) r_regs[r] <= w_wb_val[r];
            end
            if (flush_i) begin
                for (int r = 0; r < NREGS; r++) r_pend[r] <= '0;
                r_err <= 1'b0;
            end else begin
                for (int r = 0; r < NREGS; r++) r_pend[r] <= w_pend_nxt[r];
                if (|w_under) r_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
